// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : config_pkg
//  Description : Minimal core configuration record. It carries the fields the
//                return-address stack consumes (RAS depth, virtual address
//                width) and the default build configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

    typedef struct packed {
        int unsigned RASDepth;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t BUILD_CFG = '{RASDepth: 32'd2, VLEN: 32'd64};

endpackage
`default_nettype wire

// File: rtl/ras_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ras_pkg
//  Description : Shared types, constants and helpers for the return-address
//                stack. The entry record itself depends on the address width,
//                so it is declared inside ras_ring_stack where the width is
//                known.
//  Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

    // Width of the overflow/underflow statistics counters
    localparam int unsigned RAS_CNT_W = 16;

    // Direction of a pointer step
    typedef enum logic {
        RAS_DIR_DOWN = 1'b0,
        RAS_DIR_UP   = 1'b1
    } ras_dir_e;

    // Step a ring pointer by one with explicit wrap; works for any depth >= 1,
    // power of two or not.
    function automatic int unsigned ras_ptr_wrap(
        input int unsigned ptr,
        input ras_dir_e    dir,
        input int unsigned depth
    );
        if (dir == RAS_DIR_UP) begin
            return (ptr >= depth - 1) ? 0 : ptr + 1;
        end
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ras_sat_counter
//  Description : Saturating up-counter with synchronous clear. Holds at the
//                all-ones value once reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_sat_counter
    import ras_pkg::*;
#(
    parameter int unsigned WIDTH = RAS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count events, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ras_ring_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_ring_stack
//  Description : Return-address stack for the frontend branch predictor,
//                built as a circular buffer. Calls push, returns pop; a push
//                into a full stack overwrites the oldest entry.
//                Optional feature macro: CVA6_RAS_STATS_EN adds saturating
//                overflow/underflow event counters on ovf_cnt_o/unf_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_ring_stack
    import ras_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::BUILD_CFG,
    parameter int unsigned DEPTH = CVA6Cfg.RASDepth,
    parameter int unsigned AW    = CVA6Cfg.VLEN
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [AW-1:0]        push_addr_i,
    output logic [AW-1:0]        top_o,
    output logic                 top_valid_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic [RAS_CNT_W-1:0] ovf_cnt_o,
    output logic [RAS_CNT_W-1:0] unf_cnt_o
);

    localparam int unsigned        c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned        c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] ra;
    } ras_entry_t;

    ras_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic [c_PTR_W-1:0] w_ptr_inc;
    logic [c_PTR_W-1:0] w_ptr_dec;
    logic               w_full;
    logic               w_empty;
    logic               w_ovf_evt;
    logic               w_unf_evt;

    assign w_ptr_inc = c_PTR_W'(ras_ptr_wrap(32'(r_ptr), RAS_DIR_UP,   DEPTH));
    assign w_ptr_dec = c_PTR_W'(ras_ptr_wrap(32'(r_ptr), RAS_DIR_DOWN, DEPTH));
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);

    // A flush swallows any push/pop in the same cycle, so it also masks events
    assign w_ovf_evt = !flush_i && push_i && !pop_i && w_full;
    assign w_unf_evt = !flush_i && pop_i && !push_i && w_empty;

    // Stack state: reset/flush clear everything, otherwise apply push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_overflow  <= w_ovf_evt;
            r_underflow <= w_unf_evt;
            case ({push_i, pop_i})
                2'b11: begin
                    // Return and call together: replace the top in place
                    r_mem[r_ptr] <= '{valid: 1'b1, ra: push_addr_i};
                    if (w_empty) begin
                        r_count <= c_CNT_W'(1);
                    end
                end
                2'b10: begin
                    // When full this lands on the oldest entry
                    r_ptr            <= w_ptr_inc;
                    r_mem[w_ptr_inc] <= '{valid: 1'b1, ra: push_addr_i};
                    if (!w_full) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (!w_empty) begin
                        r_mem[r_ptr].valid <= 1'b0;
                        r_ptr              <= w_ptr_dec;
                        r_count            <= r_count - c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign top_o       = r_mem[r_ptr].ra;
    assign top_valid_o = !w_empty;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

`ifdef CVA6_RAS_STATS_EN
    ras_sat_counter #(
        .WIDTH (RAS_CNT_W)
    ) u_ovf_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .i_inc (w_ovf_evt),
        .o_cnt (ovf_cnt_o)
    );

    ras_sat_counter #(
        .WIDTH (RAS_CNT_W)
    ) u_unf_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .i_inc (w_unf_evt),
        .o_cnt (unf_cnt_o)
    );
`else
    assign ovf_cnt_o = '0;
    assign unf_cnt_o = '0;
`endif

endmodule
`default_nettype wire
